pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg_if.sv | 24 ++
 rtl/pipe_stage_reg.sv | 102 ++++++++++
 tb/tb_pipe_stage_reg.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_reg_if.sv
// pipe_stage_reg_if: valid/ready handshake bundle around one pipeline stage
// master: the surrounding pipeline, which drives in_valid/in_data/in_ctrl and out_ready
// slave: the stage, which drives in_ready and out_valid/out_data/out_ctrl
interface pipe_stage_reg_if #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    modport master (
        output in_valid, in_data, in_ctrl, out_ready,
        input  in_ready, out_valid, out_data, out_ctrl
    );
    modport slave (
        input  in_valid, in_data, in_ctrl, out_ready,
        output in_ready, out_valid, out_data, out_ctrl
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: pipeline register stage with valid/ready handshake, flush and stall counter
// Ports: clk; rst_n (async, active-low); flush (drops held and incoming beats);
//   bus (slave side of pipe_stage_reg_if: in_* upstream, out_* downstream);
//   stall_cnt (saturating count of cycles with out_valid=1 and out_ready=0).
// Build option: define PIPE_STAGE_SKID_EN for a 2-entry skid buffer with registered in_ready.
module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    pipe_stage_reg_if.slave  bus,
    output logic [CNT_W-1:0] stall_cnt
);
`ifdef PIPE_STAGE_SKID_EN
    typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;
`else
    typedef enum logic [1:0] {EMPTY, FULL} state_t;
`endif
    state_t            state;
    logic [DATA_W-1:0] data_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic              take_in;
    logic              take_out;
`ifdef PIPE_STAGE_SKID_EN
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic              rdy_q;
    // in_ready comes straight from a flop, cutting the out_ready->in_ready path
    assign bus.in_ready = rdy_q;
`else
    assign bus.in_ready = bus.out_ready | ~bus.out_valid;
`endif
    assign bus.out_valid = state != EMPTY;
    assign bus.out_data  = data_q;
    // ctrl_q is zeroed whenever the stage empties, so out_ctrl reads zero while idle
    assign bus.out_ctrl  = ctrl_q;
    assign take_in  = bus.in_valid & bus.in_ready;
    assign take_out = bus.out_valid & bus.out_ready;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            data_q    <= '0;
            ctrl_q    <= '0;
            stall_cnt <= '0;
`ifdef PIPE_STAGE_SKID_EN
            skid_data <= '0;
            skid_ctrl <= '0;
            rdy_q     <= 1'b1;
`endif
        end else begin
            if (bus.out_valid && !bus.out_ready && !(&stall_cnt))
                stall_cnt <= stall_cnt + 1'b1;
            if (flush) begin
                state  <= EMPTY;
                ctrl_q <= '0;
`ifdef PIPE_STAGE_SKID_EN
                rdy_q  <= 1'b1;
`endif
            end else begin
                unique case (state)
                    EMPTY: if (take_in) begin
                        state  <= FULL;
                        data_q <= bus.in_data;
                        ctrl_q <= bus.in_ctrl;
                    end
                    FULL: begin
                        if (take_in && take_out) begin
                            data_q <= bus.in_data;
                            ctrl_q <= bus.in_ctrl;
                        end else if (take_out) begin
                            state  <= EMPTY;
                            ctrl_q <= '0;
                        end
`ifdef PIPE_STAGE_SKID_EN
                        else if (take_in) begin
                            state     <= SKID;
                            skid_data <= bus.in_data;
                            skid_ctrl <= bus.in_ctrl;
                            rdy_q     <= 1'b0;
                        end
`endif
                    end
`ifdef PIPE_STAGE_SKID_EN
                    SKID: if (take_out) begin
                        state  <= FULL;
                        data_q <= skid_data;
                        ctrl_q <= skid_ctrl;
                        rdy_q  <= 1'b1;
                    end
`endif
                    default: begin
                        state  <= EMPTY;
                        ctrl_q <= '0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed + random scoreboard bench for pipe_stage_reg (either build)
module tb_pipe_stage_reg;
    localparam int DW = 32;
    localparam int CW = 8;
    localparam int NW = 4;
    typedef struct packed {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } beat_t;
    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic [NW-1:0] stall_cnt;
    pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) bus ();
    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .bus      (bus),
        .stall_cnt(stall_cnt)
    );
    always #5 clk = ~clk;
    beat_t         q[$];
    logic [DW-1:0] last_head = '0;
    logic [NW-1:0] stall_m   = '0;
    int            total     = 0;
    int            bad       = 0;
    logic          acc;
    function automatic logic exp_ready();
`ifdef PIPE_STAGE_SKID_EN
        return q.size() != 2;
`else
        return bus.out_ready || q.size() == 0;
`endif
    endfunction
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic check();
        beat_t h;
        if (q.size() > 0) begin
            h = q[0];
            last_head = h.d;
        end else begin
            h.d = last_head;
            h.c = '0;
        end
        chk("out_valid", 64'(bus.out_valid), 64'(q.size() > 0));
        chk("in_ready", 64'(bus.in_ready), 64'(exp_ready()));
        chk("out_data", 64'(bus.out_data), 64'(h.d));
        chk("out_ctrl", 64'(bus.out_ctrl), 64'(h.c));
        chk("stall_cnt", 64'(stall_cnt), 64'(stall_m));
    endtask
    task automatic model_reset();
        q.delete();
        last_head = '0;
        stall_m   = '0;
    endtask
    // one clock: check outputs at the falling edge, then advance the model across the rising edge
    task automatic step();
        beat_t b;
        logic  rs, fl, rd, pop;
        @(negedge clk);
        check();
        b.d = bus.in_data;
        b.c = bus.in_ctrl;
        rs  = rst_n;
        fl  = flush;
        rd  = bus.out_ready;
        acc = rs && !fl && bus.in_valid && exp_ready();
        pop = q.size() > 0 && rd;
        @(posedge clk);
        if (rs) begin
            if (q.size() > 0 && !rd && stall_m != '1) stall_m++;
            if (fl) q.delete();
            else begin
                if (pop) void'(q.pop_front());
                if (acc) q.push_back(b);
            end
        end
        #1;
    endtask
    initial begin
        logic [31:0] r;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'hAAAA;
        bus.in_ctrl   = 8'h77;
        repeat (3) step();
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        step();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 32'h100 + 32'(4 * i);
            bus.in_ctrl  = 8'(i + 1);
            step();
        end
        bus.in_valid = 1'b0;
        repeat (2) step();
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hDEADBEEF;
        bus.in_ctrl  = 8'h5A;
        step();
        bus.out_ready = 1'b0;
        bus.in_data   = 32'h1234;
        bus.in_ctrl   = 8'h34;
        repeat (5) begin
            step();
            if (acc) bus.in_valid = 1'b0;
        end
        chk("stall5", 64'(stall_cnt), 64'd5);
        chk("stall_hold_data", 64'(bus.out_data), 64'h0DEADBEEF);
        bus.out_ready = 1'b1;
        repeat (4) begin
            step();
            if (acc) bus.in_valid = 1'b0;
        end
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'h55;
        bus.in_ctrl   = 8'h11;
        step();
        bus.in_data = 32'hBAD;
        bus.in_ctrl = 8'hFF;
        flush = 1'b1;
        step();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        chk("flush_valid", 64'(bus.out_valid), 64'd0);
        chk("flush_ctrl", 64'(bus.out_ctrl), 64'd0);
        bus.out_ready = 1'b1;
        repeat (3) step();
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h77;
        bus.in_ctrl  = 8'h07;
        step();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        repeat (20) step();
        chk("sat", 64'(stall_cnt), 64'hF);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_valid", 64'(bus.out_valid), 64'd0);
        chk("arst_ctrl", 64'(bus.out_ctrl), 64'd0);
        chk("arst_data", 64'(bus.out_data), 64'd0);
        chk("arst_stall", 64'(stall_cnt), 64'd0);
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hCAFE;
        bus.in_ctrl  = 8'hCA;
        repeat (2) step();
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        step();
        repeat (400) begin
            r = $urandom;
            bus.in_valid  = r[0];
            bus.out_ready = r[2:1] != 2'b00;
            flush         = r[7:3] == 5'd0;
            bus.in_ctrl   = r[15:8];
            bus.in_data   = $urandom;
            step();
        end
        flush = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) step();
        chk("drain_valid", 64'(bus.out_valid), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
